cache_controller: RTL



---
 rtl/cache_controller_if.sv | 48 ++++
 rtl/cache_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
// Bundle of CPU, cache and SRAM side signals around the cache sequencing controller.
// master is the controller's view; slave is the surrounding CPU/cache/SRAM view.
interface cache_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  logic [16:0] cache_address;
  logic [63:0] cache_write_data;
  logic        cache_read_en;
  logic        cache_write_en;
  logic        cache_invoke_en;
  logic [31:0] cache_read_data;
  logic        cache_hit;

  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    input  mem_r_en, mem_w_en, address, write_data,
    output read_data, ready,
    output cache_address, cache_write_data, cache_read_en, cache_write_en, cache_invoke_en,
    input  cache_read_data, cache_hit,
    output sram_address, sram_write_data, sram_r_en, sram_w_en,
    input  sram_rdata, sram_ready,
    output hit_count, miss_count
  );

  modport slave (
    output mem_r_en, mem_w_en, address, write_data,
    input  read_data, ready,
    input  cache_address, cache_write_data, cache_read_en, cache_write_en, cache_invoke_en,
    output cache_read_data, cache_hit,
    input  sram_address, sram_write_data, sram_r_en, sram_w_en,
    output sram_rdata, sram_ready,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// Sequencer between the memory stage, a two-way read cache and the SRAM controller:
// zero-stall read hits, line fill on read miss, write-through no-allocate stores.
module cache_controller (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_line_word;
  logic        r_op_read;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  logic        w_ready;
  logic [31:0] w_read_data;
  logic        w_cache_read_en;
  logic        w_cache_write_en;
  logic        w_cache_invoke_en;
  logic        w_sram_r_en;
  logic        w_sram_w_en;
  logic        w_hit_inc;
  logic        w_miss_inc;
  logic [31:0] w_sel_word;

  assign w_sel_word = bus.address[2] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and strobe decode; requests are ignored while rst is high
  always_comb begin
    w_next            = r_state;
    w_ready           = 1'b0;
    w_read_data       = 32'd0;
    w_cache_read_en   = 1'b0;
    w_cache_write_en  = 1'b0;
    w_cache_invoke_en = 1'b0;
    w_sram_r_en       = 1'b0;
    w_sram_w_en       = 1'b0;
    w_hit_inc         = 1'b0;
    w_miss_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (rst) begin
          w_next = S_IDLE;
        end else if (bus.mem_w_en) begin
          w_cache_invoke_en = 1'b1;
          w_ready           = 1'b0;
          w_next            = S_WRITE;
        end else if (bus.mem_r_en) begin
          if (bus.cache_hit) begin
            w_read_data     = bus.cache_read_data;
            w_cache_read_en = 1'b1;
            w_hit_inc       = 1'b1;
          end else begin
            w_ready    = 1'b0;
            w_miss_inc = 1'b1;
            w_next     = S_READ;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        w_sram_r_en = 1'b1;
        if (bus.sram_ready) begin
          w_cache_write_en = 1'b1;
          w_next           = S_DONE;
        end else begin
          w_next = S_READ;
        end
      end
      S_WRITE: begin
        w_sram_w_en = 1'b1;
        if (bus.sram_ready) w_next = S_DONE;
        else                w_next = S_WRITE;
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_read_data = r_op_read ? r_line_word : 32'd0;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Remember the transaction type and capture the requested word of the fill line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_word <= 32'd0;
      r_op_read   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_op_read <= (w_next == S_READ);
      if (w_cache_write_en)  r_line_word <= w_sel_word;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= 16'd0;
      r_miss_count <= 16'd0;
    end else begin
      if (w_hit_inc && (r_hit_count != 16'hFFFF))   r_hit_count  <= r_hit_count + 16'd1;
      if (w_miss_inc && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  // 17-bit word address: line index/tag above, word offset in bit 0
  assign bus.cache_address    = bus.address[18:2];
  assign bus.cache_write_data = bus.sram_rdata;
  assign bus.cache_read_en    = w_cache_read_en;
  assign bus.cache_write_en   = w_cache_write_en;
  assign bus.cache_invoke_en  = w_cache_invoke_en;
  assign bus.sram_address     = bus.mem_w_en ? bus.address : {bus.address[31:3], 3'b000};
  assign bus.sram_write_data  = bus.write_data;
  assign bus.sram_r_en        = w_sram_r_en;
  assign bus.sram_w_en        = w_sram_w_en;
  assign bus.ready            = w_ready;
  assign bus.read_data        = w_read_data;
  assign bus.hit_count        = r_hit_count;
  assign bus.miss_count       = r_miss_count;

endmodule
